// File: rtl/serial_rx_fifo_pkg.sv
// Shared types and defaults for the serial receive path.
package serial_rx_fifo_pkg;

  typedef logic       Bit_t;
  typedef logic [7:0] Byte_t;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } Serial_rx_state_t;

  localparam int unsigned DEFAULT_OVERSAMPLE = 16;

  // Clocks per oversample tick, rounded to nearest.
  function automatic int unsigned calc_div(input int unsigned clk_freq,
                                           input int unsigned baud,
                                           input int unsigned os);
    return (clk_freq + (baud * os) / 2) / (baud * os);
  endfunction

endpackage

// File: rtl/serial_byte_fifo.sv
// Show-ahead byte FIFO with occupancy count and a drop pulse for pushes
// refused while full. Head reads as zero when empty.
module serial_byte_fifo
  import serial_rx_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [7:0]                 push_data,
  input  logic                       pop,
  output logic [7:0]                 rd_data,
  output logic                       not_empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       drop
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  Byte_t          mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           empty;
  logic           do_push;
  logic           do_pop;

  // Pop only when something is there; a full FIFO still accepts a push
  // when the same cycle frees a slot.
  always_comb begin
    empty     = (count == '0);
    full      = (count == CW'(DEPTH));
    not_empty = !empty;
    do_pop    = pop && !empty;
    do_push   = push && (!full || do_pop);
    drop      = push && full && !do_pop;
    rd_data   = empty ? '0 : mem[rd_ptr];
  end

  // Storage write; contents need no reset since the head is masked when empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/serial_rx_fifo.sv
// 8N1 UART receiver with 16x oversampling, start-bit glitch rejection,
// sticky framing/overrun flags and a show-ahead receive FIFO.
module serial_rx_fifo
  import serial_rx_fifo_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 25000000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned OVERSAMPLE = DEFAULT_OVERSAMPLE,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rxd,
  input  logic                          rd_en,
  output logic [7:0]                    rd_data,
  output logic                          rx_valid,
  output logic                          rx_full,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_err,
  output logic                          overrun,
  input  logic                          err_clear
);

  localparam int unsigned DIV   = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned SC_W  = $clog2(OVERSAMPLE);

  logic              sync1;
  logic              rxs;
  logic [DIV_W-1:0]  div_cnt;
  logic              tick;
  Serial_rx_state_t  state;
  logic [SC_W-1:0]   sc;
  logic [2:0]        bit_idx;
  Byte_t             shift;
  logic              push_req;
  logic              start_edge;
  logic              mid_start;
  logic              bit_end;
  logic              stop_sample;
  logic              fe_set;
  logic              drop;

  // Two-flop synchronizer; idle-high reset value avoids a false start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= rxd;
      rxs   <= sync1;
    end
  end

  // Decode of sampling points in the current state.
  always_comb begin
    tick        = (div_cnt == DIV_W'(DIV - 1));
    start_edge  = (state == IDLE) && !rxs;
    mid_start   = (state == START) && tick && (sc == SC_W'(OVERSAMPLE / 2 - 1));
    bit_end     = tick && (sc == SC_W'(OVERSAMPLE - 1));
    stop_sample = (state == STOP) && bit_end;
    fe_set      = stop_sample && !rxs;
  end

  // Oversample tick divider, re-phased to the detected start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          div_cnt <= '0;
    else if (start_edge) div_cnt <= '0;
    else if (tick)       div_cnt <= '0;
    else                 div_cnt <= div_cnt + DIV_W'(1);
  end

  // Frame FSM: mid-start qualification, LSB-first data capture, stop check.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sc       <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      push_req <= 1'b0;
    end else begin
      push_req <= 1'b0;
      case (state)
        IDLE: begin
          if (!rxs) begin
            state <= START;
            sc    <= '0;
          end
        end
        START: begin
          if (mid_start) begin
            if (rxs) begin
              state <= IDLE;
            end else begin
              state   <= DATA;
              sc      <= '0;
              bit_idx <= '0;
            end
          end else if (tick) begin
            sc <= sc + SC_W'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            shift[bit_idx] <= rxs;
            sc             <= '0;
            bit_idx        <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= STOP;
          end else if (tick) begin
            sc <= sc + SC_W'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            sc <= '0;
            if (rxs) begin
              push_req <= 1'b1;
              state    <= IDLE;
            end else begin
              state <= WAIT_IDLE;
            end
          end else if (tick) begin
            sc <= sc + SC_W'(1);
          end
        end
        WAIT_IDLE: begin
          if (rxs) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Sticky framing error; a clear wins over a same-cycle set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         frame_err <= 1'b0;
    else if (err_clear) frame_err <= 1'b0;
    else if (fe_set)    frame_err <= 1'b1;
  end

  // Sticky overrun; a clear wins over a same-cycle drop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         overrun <= 1'b0;
    else if (err_clear) overrun <= 1'b0;
    else if (drop)      overrun <= 1'b1;
  end

  serial_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_req),
    .push_data (shift),
    .pop       (rd_en),
    .rd_data   (rd_data),
    .not_empty (rx_valid),
    .full      (rx_full),
    .count     (fifo_count),
    .drop      (drop)
  );

endmodule

// File: tb/tb_serial_rx_fifo.sv
// Directed bench for serial_rx_fifo at a scaled-down line rate
// (4 clocks per tick, 64 clocks per bit).
module tb_serial_rx_fifo;

  localparam int BIT_CLKS   = 64;
  localparam int FRAME_CLKS = 10 * BIT_CLKS;
  localparam int PUSH_K     = 611;  // negedge index before the push edge

  logic       clk;
  logic       rst_n;
  logic       rxd;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rx_valid;
  logic       rx_full;
  logic [3:0] fifo_count;
  logic       frame_err;
  logic       overrun;
  logic       err_clear;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  serial_rx_fifo #(
    .CLK_FREQ   (6400000),
    .BAUD       (100000),
    .OVERSAMPLE (16),
    .FIFO_DEPTH (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rxd        (rxd),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .rx_valid   (rx_valid),
    .rx_full    (rx_full),
    .fifo_count (fifo_count),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .err_clear  (err_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_clks(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Drives the first len negedges of a frame; pop_at pulses rd_en at that index.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                            input int pop_at, input int len);
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      if (k / BIT_CLKS == 0)      rxd = 1'b0;
      else if (k / BIT_CLKS == 9) rxd = stop_bit;
      else                        rxd = b[k / BIT_CLKS - 1];
      rd_en = (k == pop_at);
    end
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_frame(b, 1'b1, -1, FRAME_CLKS);
  endtask

  task automatic read_expect(input string tag, input logic [7:0] exp);
    check(tag, rd_data, exp);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic pulse_clear();
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; rxd = 1'b1; rd_en = 1'b0; err_clear = 1'b0;
    idle_clks(4);
    check("reset_valid", rx_valid, 0);
    check("reset_full", rx_full, 0);
    check("reset_count", fifo_count, 0);
    check("reset_rd_data", rd_data, 0);
    check("reset_frame_err", frame_err, 0);
    check("reset_overrun", overrun, 0);
    rst_n = 1'b1;
    idle_clks(10);

    // Single frame
    send_byte(8'h55);
    check("f55_valid", rx_valid, 1);
    check("f55_count", fifo_count, 1);
    read_expect("f55_data", 8'h55);
    check("f55_empty_valid", rx_valid, 0);
    check("f55_empty_data", rd_data, 0);

    // Start-bit glitch rejected
    rxd = 1'b0;
    idle_clks(20);
    rxd = 1'b1;
    idle_clks(100);
    check("glitch_count", fifo_count, 0);
    check("glitch_valid", rx_valid, 0);
    send_byte(8'hA3);
    check("fA3_count", fifo_count, 1);
    read_expect("fA3_data", 8'hA3);

    // Framing error followed by a break
    send_frame(8'h3C, 1'b0, -1, FRAME_CLKS);
    idle_clks(20 * BIT_CLKS);
    check("break_frame_err", frame_err, 1);
    check("break_count", fifo_count, 0);
    pulse_clear();
    idle_clks(10 * BIT_CLKS);
    check("break_single_err", frame_err, 0);
    rxd = 1'b1;
    idle_clks(100);
    check("break_release_err", frame_err, 0);
    check("break_release_count", fifo_count, 0);
    send_byte(8'h7E);
    check("f7E_frame_err", frame_err, 0);
    check("f7E_count", fifo_count, 1);
    read_expect("f7E_data", 8'h7E);

    // Fill and overflow
    for (int i = 1; i <= 8; i++) send_byte(8'(i));
    check("fill_full", rx_full, 1);
    check("fill_count", fifo_count, 8);
    check("fill_no_overrun", overrun, 0);
    send_byte(8'h09);
    check("ovf_overrun", overrun, 1);
    check("ovf_count", fifo_count, 8);
    for (int i = 1; i <= 8; i++) read_expect("ovf_read", 8'(i));
    check("ovf_drained_valid", rx_valid, 0);
    check("ovf_drained_full", rx_full, 0);
    pulse_clear();
    check("ovf_cleared", overrun, 0);

    // Push and pop on the same cycle while full
    for (int i = 1; i <= 8; i++) send_byte(8'(i));
    check("pp_full_before", fifo_count, 8);
    send_frame(8'h09, 1'b1, PUSH_K, FRAME_CLKS);
    check("pp_no_overrun", overrun, 0);
    check("pp_count", fifo_count, 8);
    for (int i = 2; i <= 9; i++) read_expect("pp_read", 8'(i));
    check("pp_drained", rx_valid, 0);

    // Reset during bit 4 of a frame
    send_byte(8'h11);
    check("pre_reset_count", fifo_count, 1);
    send_frame(8'hC6, 1'b1, -1, 5 * BIT_CLKS + 32);
    rst_n = 1'b0;
    rxd   = 1'b1;
    idle_clks(3);
    check("midrst_valid", rx_valid, 0);
    check("midrst_count", fifo_count, 0);
    check("midrst_rd_data", rd_data, 0);
    check("midrst_frame_err", frame_err, 0);
    rst_n = 1'b1;
    idle_clks(20 * BIT_CLKS);
    check("postrst_count", fifo_count, 0);
    send_byte(8'h81);
    check("f81_count", fifo_count, 1);
    check("f81_frame_err", frame_err, 0);
    read_expect("f81_data", 8'h81);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/serial_rx_fifo.md
Name: serial_rx_fifo

Overview:
- Receive-direction serial engine for the external UART path: 8N1 frames in on `rxd`, bytes out through a small show-ahead FIFO to the bus-side serial controller.
- Replaces the single-byte receive latch, so back-to-back frames are not lost while the CPU is slow to poll.
- Uses 16x oversampling with mid-bit sampling, glitch rejection on the start bit, and sticky framing/overrun flags.

Parameters:
- CLK_FREQ, 25000000, input clock frequency in Hz.
- BAUD, 9600, line rate in bits/s.
- OVERSAMPLE, 16, ticks per bit; must be even.
- FIFO_DEPTH, 8, entries; power of 2, at least 2.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset.
- rxd  in  1  asynchronous serial input; idle high.
- rd_en  in  1  pops the head entry; ignored when empty.
- rd_data  out  8  head entry (show-ahead); 0 when empty.
- rx_valid  out  1  FIFO not empty.
- rx_full  out  1  FIFO full.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- frame_err  out  1  sticky; a stop bit was sampled low.
- overrun  out  1  sticky; a byte was dropped because the FIFO was full.
- err_clear  in  1  clears both sticky flags.

Interface rule (already decided): one clock `clk`; reset `rst_n` is asynchronous and active-low.

Behaviour:
- Reset (async assert):
  - Synchronizer stages = 1, FSM = IDLE, counters = 0, pointers = 0.
  - Outputs: rx_valid 0, rx_full 0, fifo_count 0, rd_data 0, frame_err 0, overrun 0.
  - Release is synchronous to clk.
  - Reset mid-frame abandons the frame; nothing is pushed.
- Synchronizer: `rxd` passes through 2 flops. The FSM sees only the synced value `rxs`.
- Tick generator:
  - DIV = (CLK_FREQ + BAUD*OVERSAMPLE/2) / (BAUD*OVERSAMPLE), integer rounding; 163 at defaults.
  - Free-running counter issues a one-cycle `tick` every DIV clocks.
  - The counter restarts at 0 on the IDLE->START transition so sampling phase aligns to the detected edge.
- FSM (sample counter `sc` counts ticks, 4 bits at defaults):
  - IDLE: when rxs == 0, go to START and set sc = 0.
  - START: on tick, sc++. At sc == OVERSAMPLE/2-1 (mid start bit):
    - rxs == 1 -> IDLE (glitch rejected).
    - otherwise -> DATA, with sc = 0 and bit index = 0.
  - DATA: on tick, sc++. When sc wraps at OVERSAMPLE-1, sample rxs into shift[bit] (LSB first) and increment bit. After bit 7 -> STOP.
  - STOP: sample at the same mid-bit point.
    - rxs == 1 -> push byte, go to IDLE.
    - rxs == 0 -> set frame_err, discard byte, go to WAIT_IDLE.
  - WAIT_IDLE: stay until rxs == 1, then go to IDLE. A break condition (line held low) produces exactly one frame_err and no bytes.
- FIFO:
  - Storage is a register array.
  - rd_data = mem[rd_ptr] while not empty, else 0.
  - The push takes effect on the clock after the stop-bit sample. rx_valid rises the following cycle, so latency is 1 clk from push.
  - Push while full with no pop in the same cycle: byte dropped, overrun set, FIFO contents unchanged.
  - Push while full with rd_en in the same cycle: both happen; count stays FIFO_DEPTH; no overrun.
  - Push and pop on a non-empty FIFO: count unchanged.
  - rd_en while empty: no effect.
  - Pointers wrap modulo FIFO_DEPTH. fifo_count holds 0..FIFO_DEPTH.
- Flags:
  - err_clear takes priority over a same-cycle set. The event is lost, and this is documented behaviour.
  - Flags never clear by themselves.

Decomposition:
- `peripheral_defines.svh` gets:
  - Bit_t and Byte_t (already present).
  - A new enum `Serial_rx_state_t` {IDLE, START, DATA, STOP, WAIT_IDLE}.
  - A constant for the default OVERSAMPLE.
- One sub-module, `serial_byte_fifo` (parameterised depth, show-ahead, count output). It is reusable later for a TX-side FIFO.
- The FSM and tick generator stay in `serial_rx_fifo`.

Test Plan:
- Single frame 0x55 at 9600 baud (bit = 2608 clk) -> about 9.5 bit times after the start edge: rx_valid = 1, rd_data = 0x55, fifo_count = 1. After one rd_en: rx_valid = 0, rd_data = 0.
- Low glitch of 5 ticks (815 clk) on idle line -> no push, FSM back in IDLE. A following 0xA3 frame is received as 0xA3.
- Frame 0x3C with stop bit driven 0, then line held low for 20 bit times -> frame_err = 1, fifo_count = 0, exactly one error and no bytes. After rxd goes high and err_clear pulses: frame_err = 0, and 0x7E is received cleanly.
- Nine frames 0x01..0x09, no reads, depth 8 -> rx_full = 1 after 0x08, overrun = 1 after 0x09. Eight reads return 0x01..0x08, then rx_valid = 0.
- FIFO full (0x01..0x08) with rd_en asserted on the exact push cycle of 0x09 -> overrun stays 0, fifo_count stays 8. Subsequent reads return 0x02..0x09.
- rst_n pulsed low during bit 4 of 0xC6, then frame 0x81 sent -> all outputs reset, no partial byte pushed, rd_data = 0x81 with fifo_count = 1.
